// File: rtl/zacore_fetch.sv
// ---------------------------------------------------------------------------
// zacore_fetch
//   Fetch stage of the Zacore pipeline. Generates sequential PCs, issues
//   requests on an in-order instruction memory port, buffers the responses in
//   a small FIFO and presents {valid, pc, inst} to decode. A redirect from
//   execute flushes the buffer and marks every in-flight request as stale so
//   its response is discarded on arrival.
//
// Ports
//   clk               in   1   clock
//   rst               in   1   synchronous, active-high reset
//   i_execute_fetch   in   32  {valid, pc[31:1]}; valid=1 redirects to pc
//   i_stall           in   1   decode cannot accept this cycle
//   o_fetch_decode    out  64  {valid, pc[31:1], inst[31:0]} (FIFO head)
//   o_imem_req_valid  out  1   instruction memory request valid
//   i_imem_req_ready  in   1   memory accepts the request this cycle
//   o_imem_addr       out  32  request byte address, bits [1:0]=0
//   i_imem_rsp_valid  in   1   in-order response valid
//   i_imem_rsp_data   in   32  instruction word
// ---------------------------------------------------------------------------
module zacore_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_execute_fetch,
    input  logic        i_stall,
    output logic [63:0] o_fetch_decode,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);  // FIFO pointer width
    localparam int unsigned CW = PW + 1;              // counts 0..FIFO_DEPTH
    localparam int unsigned OW = CW + 1;              // inflight + buffered sum

    typedef logic [30:0] pc_t;  // halfword-granular PC, byte address [31:1]

    typedef struct packed {
        logic valid;
        pc_t  pc;
    } datapath_info_t;

    typedef struct packed {
        datapath_info_t datapath_info;
    } execute_fetch_if_t;

    typedef struct packed {
        datapath_info_t datapath_info;
        logic [31:0]    inst;
    } fetch_decode_if_t;

    // DRAIN means stale responses are still owed by memory
    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    execute_fetch_if_t ef_s;
    fetch_decode_if_t  fd_s;

    pc_t            fetch_pc_q, fetch_pc_d;
    pc_t            rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]  inflight_q, inflight_d;
    logic [CW-1:0]  drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    state_e         state_q, state_d;

    pc_t            fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]    fifo_inst_q [FIFO_DEPTH];

    logic           redirect_s;
    pc_t            target_s;
    logic [OW-1:0]  occupancy_s;
    logic           req_valid_s;
    logic           req_fire_s;
    logic           out_valid_s;
    logic           pop_s;
    logic           push_s;
    logic           full_s;

    assign ef_s = execute_fetch_if_t'(i_execute_fetch);

    // Handshake and control decode for the current cycle
    always_comb begin
        redirect_s  = ef_s.datapath_info.valid;
        // Byte bit 1 is cleared: only 32-bit aligned instructions are fetched
        target_s    = ef_s.datapath_info.pc & 31'h7FFF_FFFE;
        occupancy_s = OW'(inflight_q) + OW'(count_q);
        // Capacity rule: never more requests outstanding than buffer slots
        req_valid_s = !rst && !redirect_s && (occupancy_s < OW'(FIFO_DEPTH));
        req_fire_s  = req_valid_s && i_imem_req_ready;
        out_valid_s = !rst && !redirect_s && (count_q != {CW{1'b0}});
        pop_s       = out_valid_s && !i_stall;
        push_s      = !rst && i_imem_rsp_valid && !redirect_s && (state_q == ST_FETCH);
        full_s      = (count_q == CW'(FIFO_DEPTH));
    end

    // Next-state computation; redirect overrides every other update
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (redirect_s) begin
            fetch_pc_d = target_s;
            rsp_pc_d   = target_s;
            // Every request still outstanding after this cycle is wrong-path.
            // Previously stale ones are already part of inflight, so the new
            // drop count is the outstanding total, not an additional sum.
            inflight_d = inflight_q - CW'(i_imem_rsp_valid);
            drop_cnt_d = inflight_q - CW'(i_imem_rsp_valid);
            count_d    = {CW{1'b0}};
            wr_ptr_d   = {PW{1'b0}};
            rd_ptr_d   = {PW{1'b0}};
        end else begin
            if (req_fire_s) begin
                fetch_pc_d = fetch_pc_q + 31'd2;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            inflight_d = inflight_q + CW'(req_fire_s) - CW'(i_imem_rsp_valid);
            if (i_imem_rsp_valid && (state_q == ST_DRAIN)) begin
                drop_cnt_d = drop_cnt_q - {{(CW-1){1'b0}}, 1'b1};
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
            if (push_s) begin
                rsp_pc_d = rsp_pc_q + 31'd2;
                wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                rsp_pc_d = rsp_pc_q;
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(push_s) - CW'(pop_s);
        end
        state_d = (drop_cnt_d != {CW{1'b0}}) ? ST_DRAIN : ST_FETCH;
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC[31:1];
            rsp_pc_q   <= RESET_PC[31:1];
            inflight_q <= {CW{1'b0}};
            drop_cnt_q <= {CW{1'b0}};
            count_q    <= {CW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            state_q    <= ST_FETCH;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
        end
    end

    // Instruction buffer storage; contents are qualified by count_q
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
            fifo_inst_q[wr_ptr_q] <= i_imem_rsp_data;
        end else begin
            fifo_pc_q[wr_ptr_q]   <= fifo_pc_q[wr_ptr_q];
            fifo_inst_q[wr_ptr_q] <= fifo_inst_q[wr_ptr_q];
        end
    end

    // Decode-facing view of the FIFO head and memory request port
    always_comb begin
        fd_s.datapath_info.valid = out_valid_s;
        fd_s.datapath_info.pc    = fifo_pc_q[rd_ptr_q];
        fd_s.inst                = fifo_inst_q[rd_ptr_q];
        o_fetch_decode           = fd_s;
        o_imem_req_valid         = req_valid_s;
        o_imem_addr              = {fetch_pc_q, 1'b0};
    end

    zacore_fetch_chk u_chk (
        .clk    (clk),
        .rst    (rst),
        .push_i (push_s),
        .pop_i  (pop_s),
        .full_i (full_s)
    );

endmodule

// Buffer overflow checker: a push into a full FIFO without a pop would lose data
module zacore_fetch_chk (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic pop_i,
    input  logic full_i
);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && full_i && !pop_i));
endmodule

// File: tb/tb_zacore_fetch.sv
module tb_zacore_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_execute_fetch;
    logic        i_stall;
    logic [63:0] o_fetch_decode;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;

    always #5 clk = ~clk;

    zacore_fetch #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_execute_fetch  (i_execute_fetch),
        .i_stall          (i_stall),
        .o_fetch_decode   (o_fetch_decode),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_addr      (o_imem_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data)
    );

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

    pend_t pend_q[$];   // memory model: accepted requests awaiting response
    exp_t  exp_q[$];    // scoreboard: what decode must see, in order

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mem_lat = 1;

    logic        rst_v, stall_v, ready_v, redir_v;
    logic [31:0] redir_tgt;
    logic [31:0] model_pc;
    logic        s_req_valid, s_fd_valid, s_popped;
    logic [31:0] s_addr, s_fd_pc, s_fd_inst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // One clock cycle: drive at negedge, sample #1 later, update model/scoreboard
    task automatic cycle();
        pend_t p;
        exp_t  e;
        @(negedge clk);
        cyc++;
        rst              = rst_v;
        i_stall          = stall_v;
        i_imem_req_ready = ready_v;
        i_execute_fetch  = {redir_v, redir_tgt[31:1]};
        if (rst_v) pend_q.delete();
        if (!rst_v && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            i_imem_rsp_valid = 1'b1;
            i_imem_rsp_data  = mem_word(pend_q[0].addr);
            void'(pend_q.pop_front());
        end else begin
            i_imem_rsp_valid = 1'b0;
            i_imem_rsp_data  = 32'h0;
        end
        #1;
        s_req_valid = o_imem_req_valid;
        s_addr      = o_imem_addr;
        s_fd_valid  = o_fetch_decode[63];
        s_fd_pc     = {o_fetch_decode[62:32], 1'b0};
        s_fd_inst   = o_fetch_decode[31:0];
        s_popped    = 1'b0;
        if (rst_v) begin
            exp_q.delete();
            model_pc = 32'h0000_0100;
        end else if (redir_v) begin
            exp_q.delete();
            model_pc = redir_tgt & 32'hFFFF_FFFC;
            checks++;
            if (s_req_valid !== 1'b0 || s_fd_valid !== 1'b0) begin
                failures++;
                $display("FAIL redirect_quiet: req_valid=%b fd_valid=%b required 0/0", s_req_valid, s_fd_valid);
            end
        end else begin
            if (s_req_valid && ready_v) begin
                checks++;
                if (s_addr !== model_pc) begin
                    failures++;
                    $display("FAIL req_addr: got %h required %h", s_addr, model_pc);
                end
                p.addr = s_addr;
                p.due  = cyc + mem_lat;
                pend_q.push_back(p);
                e.pc   = model_pc;
                e.inst = mem_word(model_pc);
                exp_q.push_back(e);
                model_pc = model_pc + 32'd4;
            end
            if (s_fd_valid && !stall_v) begin
                s_popped = 1'b1;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output: pc=%h inst=%h required no output", s_fd_pc, s_fd_inst);
                end else begin
                    e = exp_q.pop_front();
                    if (s_fd_pc !== e.pc || s_fd_inst !== e.inst) begin
                        failures++;
                        $display("FAIL decode_out: pc=%h inst=%h required pc=%h inst=%h", s_fd_pc, s_fd_inst, e.pc, e.inst);
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_v = 1'b1; stall_v = 1'b0; ready_v = 1'b1; redir_v = 1'b0;
        cycle();
        cycle();
        rst_v = 1'b0;
    endtask

    // Stop accepting requests and let everything outstanding reach decode
    task automatic drain(input string name);
        ready_v = 1'b0; stall_v = 1'b0; redir_v = 1'b0;
        for (int i = 0; i < 12; i++) cycle();
        checks++;
        if (exp_q.size() != 0 || s_fd_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_drain: left=%0d fd_valid=%b required 0/0", name, exp_q.size(), s_fd_valid);
        end
        mem_lat = 1;
    endtask

    task automatic test_reset();
        rst_v = 1'b1; stall_v = 1'b0; ready_v = 1'b1; redir_v = 1'b0;
        cycle();
        checks++;
        if (s_req_valid !== 1'b0 || s_fd_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: req_valid=%b fd_valid=%b required 0/0", s_req_valid, s_fd_valid);
        end
        cycle();
        rst_v = 1'b0;
        cycle();
        checks++;
        if (s_req_valid !== 1'b1 || s_addr !== 32'h0000_0100 || s_fd_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_req: req_valid=%b addr=%h fd_valid=%b required 1/00000100/0", s_req_valid, s_addr, s_fd_valid);
        end
        drain("reset");
    endtask

    task automatic test_stream();
        int first;
        int pops;
        first = -1; pops = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_popped) begin
                if (first < 0) first = i;
                pops++;
            end
        end
        checks++;
        if (first != 2 || pops != 18) begin
            failures++;
            $display("FAIL stream_rate: first_pop=%0d pops=%0d required 2/18", first, pops);
        end
        drain("stream");
    endtask

    task automatic test_stall();
        int accepts;
        int n;
        logic [31:0] pcs [4];
        accepts = 0; n = 0;
        do_reset();
        stall_v = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_req_valid && ready_v) accepts++;
        end
        checks++;
        if (accepts != 4 || s_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_cap: accepts=%0d req_valid=%b required 4/0", accepts, s_req_valid);
        end
        stall_v = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (s_popped && n < 4) begin
                pcs[n] = s_fd_pc;
                n++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (n != 4 || pcs[k] !== 32'h0000_0100 + 32'(4 * k)) begin
                failures++;
                $display("FAIL stall_release_pc%0d: got %h (n=%0d) required %h", k, pcs[k], n, 32'h0000_0100 + 32'(4 * k));
            end
        end
        drain("stall");
    endtask

    // Wait (bounded) for the first delivery and check its pc/inst
    task automatic expect_first_pop(input string name, input logic [31:0] pc);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            if (s_popped) got = 1'b1;
        end
        checks++;
        if (!got || s_fd_pc !== pc || s_fd_inst !== mem_word(pc)) begin
            failures++;
            $display("FAIL %s_first: seen=%b pc=%h inst=%h required pc=%h inst=%h", name, got, s_fd_pc, s_fd_inst, pc, mem_word(pc));
        end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        mem_lat = 3;
        cycle();
        cycle();
        ready_v = 1'b0; redir_v = 1'b1; redir_tgt = 32'h0000_0200;
        cycle();
        redir_v = 1'b0; ready_v = 1'b1;
        cycle();
        checks++;
        if (s_req_valid !== 1'b1 || s_addr !== 32'h0000_0200) begin
            failures++;
            $display("FAIL redirect_latency: req_valid=%b addr=%h required 1/00000200", s_req_valid, s_addr);
        end
        expect_first_pop("redirect_drop", 32'h0000_0200);
        drain("redirect_drop");
    endtask

    task automatic test_redirect_rsp_stall();
        do_reset();
        stall_v = 1'b1;
        cycle();
        cycle();
        redir_v = 1'b1; redir_tgt = 32'h0000_0300;
        cycle();
        redir_v = 1'b0;
        cycle();
        checks++;
        if (s_fd_valid !== 1'b0) begin
            failures++;
            $display("FAIL redirect_flush: fd_valid=%b required 0", s_fd_valid);
        end
        stall_v = 1'b0;
        expect_first_pop("redirect_rsp", 32'h0000_0300);
        drain("redirect_rsp");
    endtask

    task automatic test_ready_hold();
        do_reset();
        ready_v = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (s_req_valid !== 1'b1 || s_addr !== 32'h0000_0100) begin
                failures++;
                $display("FAIL ready_hold%0d: req_valid=%b addr=%h required 1/00000100", i, s_req_valid, s_addr);
            end
        end
        ready_v = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        drain("ready_hold");
    endtask

    task automatic test_reset_mid();
        do_reset();
        stall_v = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        checks++;
        if (s_fd_valid !== 1'b1 || s_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_before_reset: fd_valid=%b req_valid=%b required 1/0", s_fd_valid, s_req_valid);
        end
        rst_v = 1'b1;
        cycle();
        checks++;
        if (s_fd_valid !== 1'b0 || s_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_in: fd_valid=%b req_valid=%b required 0/0", s_fd_valid, s_req_valid);
        end
        rst_v = 1'b0; stall_v = 1'b0;
        cycle();
        checks++;
        if (s_fd_valid !== 1'b0 || s_req_valid !== 1'b1 || s_addr !== 32'h0000_0100) begin
            failures++;
            $display("FAIL reset_mid_after: fd_valid=%b req_valid=%b addr=%h required 0/1/00000100", s_fd_valid, s_req_valid, s_addr);
        end
        drain("reset_mid");
    endtask

    task automatic test_wrap();
        int n;
        logic [31:0] pcs [3];
        logic [31:0] want [3];
        n = 0;
        want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
        do_reset();
        redir_v = 1'b1; redir_tgt = 32'hFFFF_FFFA;   // bit 1 set: aligned down
        cycle();
        redir_v = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (s_popped && n < 3) begin
                pcs[n] = s_fd_pc;
                n++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (n != 3 || pcs[k] !== want[k]) begin
                failures++;
                $display("FAIL wrap_pc%0d: got %h (n=%0d) required %h", k, pcs[k], n, want[k]);
            end
        end
        drain("wrap");
    endtask

    // Second redirect while still draining stale responses
    task automatic test_back_to_back();
        do_reset();
        mem_lat = 3;
        cycle();
        cycle();
        redir_v = 1'b1; redir_tgt = 32'h0000_0500;
        cycle();
        redir_v = 1'b0;
        cycle();
        redir_v = 1'b1; redir_tgt = 32'h0000_0600;
        cycle();
        redir_v = 1'b0;
        expect_first_pop("back_to_back", 32'h0000_0600);
        drain("back_to_back");
    endtask

    initial begin
        rst = 1'b1; i_stall = 1'b0; i_imem_req_ready = 1'b0; i_execute_fetch = 32'h0;
        i_imem_rsp_valid = 1'b0; i_imem_rsp_data = 32'h0;
        rst_v = 1'b1; stall_v = 1'b0; ready_v = 1'b0; redir_v = 1'b0;
        redir_tgt = 32'h0; model_pc = 32'h0000_0100;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_rsp_stall();
        test_ready_hold();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
